// File: rtl/traffic_scheduler.sv
// traffic_scheduler: tick-driven lane move scheduler for a frogger-style game.
// A free-running prescaler makes a scheduler tick; each of eight lanes counts
// ticks and emits a one-cycle move strobe when its level-dependent period ends.
// A four-state FSM (IDLE/RUN/PAUSED/HIT) gates lane progress and difficulty.
module traffic_scheduler #(
  parameter int          TICK_DIV  = 250000,
  parameter logic [31:0] LANE_BASE = 32'h35645364,
  parameter logic [7:0]  LANE_DIR  = 8'b01010101,
  parameter int          HIT_TICKS = 50
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic       pause,
  input  logic       level_up,
  input  logic       collision,
  output logic [7:0] move_en,
  output logic [7:0] move_dir,
  output logic [2:0] level,
  output logic [1:0] state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HIT_TICKS > 0) ? $clog2(HIT_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_HIT    = 2'd3
  } state_t;

  state_t        cur;
  logic [PW-1:0] presc;
  logic          tick;
  logic [HW-1:0] hit_cnt;
  logic          hit_done;
  logic [3:0]    cnt [8];
  logic [3:0]    eff [8];
  logic [7:0]    wrap;

  assign move_dir = LANE_DIR;
  assign state    = cur;
  assign tick     = (presc == PW'(TICK_DIV - 1));
  assign hit_done = (int'(hit_cnt) + 1 >= HIT_TICKS);

  // Prescaler: free-running 0..TICK_DIV-1 in every state; tick on the last count.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours, independent of order.
    if (!RST_N) presc <= '0;
    else if (tick) presc <= '0;
    else presc <= presc + 1'b1;
  end

  // Per-lane effective period (zero nibble means 1, shortened by level, min 1)
  // and the end-of-period detect for each lane counter.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    wrap = '0;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] base;
      base = LANE_BASE[4*k +: 4];
      if (base == 4'd0) base = 4'd1;
      eff[k]  = (base > {1'b0, level}) ? base - {1'b0, level} : 4'd1;
      wrap[k] = (cnt[k] == eff[k] - 4'd1);
    end
  end

  // Control FSM with registered outputs: state, level, lane counters, hit
  // timer and the move strobes. Priority in RUN: collision > pause > level_up.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cur     <= S_IDLE;
      level   <= '0;
      hit_cnt <= '0;
      move_en <= '0;
      // NOTE: the lane counters are a small register array, not a RAM, so they
      // are reset explicitly along with the rest of the state.
      for (int k = 0; k < 8; k++) cnt[k] <= '0;
    end else begin
      move_en <= '0;
      case (cur)
        S_IDLE: begin
          if (start) begin
            cur <= S_RUN;
            for (int k = 0; k < 8; k++) cnt[k] <= '0;
          end
        end
        S_RUN: begin
          if (collision) begin
            cur     <= S_HIT;
            hit_cnt <= '0;
          end else if (pause) begin
            cur <= S_PAUSED;
          end else if (level_up) begin
            if (level != 3'd7) level <= level + 3'd1;
            for (int k = 0; k < 8; k++) cnt[k] <= '0;
          end else if (tick) begin
            move_en <= wrap;
            for (int k = 0; k < 8; k++)
              cnt[k] <= wrap[k] ? 4'd0 : cnt[k] + 4'd1;
          end
        end
        S_PAUSED: begin
          if (collision) begin
            cur     <= S_HIT;
            hit_cnt <= '0;
          end else if (!pause) begin
            cur <= S_RUN;
          end
        end
        S_HIT: begin
          if (tick) begin
            if (hit_done) begin
              cur     <= S_IDLE;
              hit_cnt <= '0;
            end else begin
              hit_cnt <= hit_cnt + HW'(1);
            end
          end
        end
        default: cur <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_scheduler.sv
// tb_traffic_scheduler: scoreboard bench. The stimulus process drives inputs on
// the falling edge, advances a behavioural model of the scheduler rules and
// queues the outputs expected after the next rising edge; a monitor pops and
// compares them shortly after each rising edge. Directed phases also measure
// move strobe spacing in cycles against values worked out by hand.
module tb_traffic_scheduler;

  localparam int          TD    = 4;
  localparam int          HT    = 3;
  localparam logic [31:0] BASE  = 32'h35645364;
  localparam logic [7:0]  DIR   = 8'b01010101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, pause = 1'b0, level_up = 1'b0, collision = 1'b0;
  logic [7:0] move_en, move_dir;
  logic [2:0] level;
  logic [1:0] state;

  traffic_scheduler #(.TICK_DIV(TD), .LANE_BASE(BASE), .LANE_DIR(DIR), .HIT_TICKS(HT)) dut (
    .CLK(clk), .RST_N(rst_n), .start(start), .pause(pause), .level_up(level_up),
    .collision(collision), .move_en(move_en), .move_dir(move_dir), .level(level), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] me;
    logic [2:0] lv;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   stim_done = 1'b0;

  // Behavioural model: progress = ticks completed in the current lane period.
  int m_presc, m_state, m_level, m_hit;
  int m_prog [8];
  logic [7:0] m_move;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff(input int k, input int lvl);
    int b;
    b = int'((BASE >> (4 * k)) & 32'hF);
    if (b == 0) b = 1;
    return (b > lvl) ? b - lvl : 1;
  endfunction

  // What happens at one rising edge, given the inputs presented before it.
  task automatic model_edge(input bit r, input bit s, input bit p, input bit lu, input bit c);
    bit tk;
    if (!r) begin
      m_presc = 0; m_state = 0; m_level = 0; m_hit = 0; m_move = '0;
      for (int k = 0; k < 8; k++) m_prog[k] = 0;
      return;
    end
    tk      = (m_presc == TD - 1);
    m_presc = tk ? 0 : m_presc + 1;
    m_move  = '0;
    case (m_state)
      0: if (s) begin
           m_state = 1;
           for (int k = 0; k < 8; k++) m_prog[k] = 0;
         end
      1: if (c) begin m_state = 3; m_hit = 0; end
         else if (p) m_state = 2;
         else if (lu) begin
           m_level = (m_level < 7) ? m_level + 1 : 7;
           for (int k = 0; k < 8; k++) m_prog[k] = 0;
         end else if (tk) begin
           for (int k = 0; k < 8; k++) begin
             m_prog[k]++;
             if (m_prog[k] == eff(k, m_level)) begin
               m_prog[k] = 0;
               m_move[k] = 1'b1;
             end
           end
         end
      2: if (c) begin m_state = 3; m_hit = 0; end
         else if (!p) m_state = 1;
      default: if (tk) begin
           m_hit++;
           if (m_hit == HT) begin m_state = 0; m_hit = 0; end
         end
    endcase
  endtask

  // One clock of stimulus: drive on the falling edge, queue the expectation.
  task automatic cycle(input bit r, input bit s, input bit p, input bit lu, input bit c);
    exp_t e;
    @(negedge clk);
    rst_n = r; start = s; pause = p; level_up = lu; collision = c;
    model_edge(r, s, p, lu, c);
    e.me = m_move; e.lv = 3'(m_level); e.st = 2'(m_state);
    q.push_back(e);
  endtask

  // Spacing in cycles between two consecutive strobes on one lane, start held.
  task automatic measure(input int lane, input int exp_cycles, input string name);
    int  n = 0;
    int  first = 0;
    bit  seen = 1'b0;
    while (n < 200) begin
      cycle(1, 1, 0, 0, 0);
      n++;
      if (move_en[lane]) begin
        if (seen) begin
          check(name, 32'(n - first), 32'(exp_cycles));
          return;
        end
        seen  = 1'b1;
        first = n;
      end
    end
    n_vec++;
    n_bad++;
    $display("FAIL %s: no strobe pair within 200 cycles, expected spacing %0d", name, exp_cycles);
  endtask

  // Monitor: compare every cycle's outputs against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("move_en", 32'(move_en), 32'(e.me));
        check("level", 32'(level), 32'(e.lv));
        check("state", 32'(state), 32'(e.st));
        check("move_dir", 32'(move_dir), 32'(DIR));
      end
    end
  end

  initial begin
    bit p_lvl;
    m_presc = 0; m_state = 0; m_level = 0; m_hit = 0; m_move = '0;
    for (int k = 0; k < 8; k++) m_prog[k] = 0;

    // Reset, then start held: base periods 4/6/3 ticks of 4 cycles.
    repeat (3) cycle(0, 0, 0, 0, 0);
    measure(0, 16, "lane0_period_lvl0");
    measure(2, 12, "lane2_period_lvl0");
    measure(1, 24, "lane1_period_lvl0");

    // Three level-ups: lanes 0, 2 and 7 clamp to one tick.
    repeat (3) begin
      cycle(1, 1, 0, 1, 0);
      cycle(1, 1, 0, 0, 0);
    end
    measure(2, 4, "lane2_period_lvl3");
    measure(7, 4, "lane7_period_lvl3");
    measure(0, 4, "lane0_period_lvl3");

    // Pause mid-period for 40 cycles, then release.
    repeat (5) cycle(1, 0, 0, 0, 0);
    repeat (40) cycle(1, 0, 1, 0, 0);
    repeat (40) cycle(1, 0, 0, 0, 0);

    // Collision together with level_up: HIT wins, level kept, back to IDLE.
    cycle(1, 0, 0, 1, 1);
    repeat (20) cycle(1, 0, 0, 0, 0);

    // Nine level-ups saturate at 7; then a one-cycle reset in RUN.
    cycle(1, 1, 0, 0, 0);
    repeat (9) begin
      cycle(1, 0, 0, 1, 0);
      cycle(1, 0, 0, 0, 0);
    end
    repeat (7) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    repeat (3) cycle(1, 0, 0, 0, 0);

    // Randomised traffic: held pause level, sparse pulses, rare resets.
    p_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit r, s, lu, c;
      if ($urandom_range(0, 29) == 0) p_lvl = ~p_lvl;
      r  = ($urandom_range(0, 499) != 0);
      s  = ($urandom_range(0, 2) == 0);
      lu = ($urandom_range(0, 39) == 0);
      c  = ($urandom_range(0, 149) == 0);
      cycle(r, s, p_lvl, lu, c);
    end

    repeat (2) cycle(1, 0, 0, 0, 0);
    stim_done = 1'b1;
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_scheduler.md
TRAFFIC_SCHEDULER -- requirements
Module: traffic_scheduler

Interface
REQ-001 The block SHALL use one clock and one reset: reset is synchronous and active-low.
REQ-002 Parameter TICK_DIV, default 250000, SHALL set the number of CLK cycles per scheduler tick.
REQ-003 Parameter LANE_BASE, default 32'h35645364, SHALL hold eight 4-bit base periods in ticks, one per lane (lane k = bits 4k+3:4k); a nibble of 0 SHALL be treated as 1.
REQ-004 Parameter LANE_DIR, default 8'b01010101, SHALL give the per-lane direction (1 = +x, 0 = -x).
REQ-005 Parameter HIT_TICKS, default 50, SHALL set the freeze duration in ticks after a collision.
REQ-006 CLK  in  1  system clock.
REQ-007 RST_N  in  1  synchronous active-low reset.
REQ-008 start  in  1  level-sensitive request to begin running.
REQ-009 pause  in  1  level-sensitive hold request.
REQ-010 level_up  in  1  one-cycle pulse: frog reached goal.
REQ-011 collision  in  1  one-cycle pulse: frog hit a car.
REQ-012 move_en  out  8  one-cycle per-lane move strobe to the car position registers.
REQ-013 move_dir  out  8  per-lane direction, constant equal to LANE_DIR.
REQ-014 level  out  3  current difficulty level, 0..7.
REQ-015 state  out  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSED, 3 HIT.

Function
REQ-016 A prescaler SHALL count 0..TICK_DIV-1 continuously in all states and assert an internal tick for one cycle when it equals TICK_DIV-1.
REQ-017 Effective lane period SHALL be eff_k = base_k - level if base_k > level, else 1.
REQ-018 Each lane SHALL own a 4-bit counter that advances only on tick while in RUN.
REQ-019 On a RUN tick where cnt_k == eff_k-1, cnt_k SHALL clear to 0 and move_en[k] SHALL be high in the following cycle only; otherwise cnt_k increments.
REQ-020 move_en SHALL be all-zero in every state other than RUN and in every cycle not following a RUN tick.
REQ-021 IDLE -> RUN when start = 1; all lane counters SHALL clear on entry to RUN from IDLE.
REQ-022 RUN -> PAUSED when pause = 1; PAUSED -> RUN when pause = 0; lane counters SHALL hold their values in PAUSED.
REQ-023 RUN or PAUSED -> HIT on collision = 1; HIT SHALL last HIT_TICKS ticks, then go to IDLE; level SHALL be preserved.
REQ-024 level_up in RUN SHALL increment level, saturating at 7, and clear all lane counters; level_up in any other state SHALL be ignored.
REQ-025 collision SHALL take priority over level_up and pause in the same cycle; pause SHALL take priority over level_up.
REQ-026 start SHALL be ignored outside IDLE; collision SHALL be ignored in IDLE and HIT.
REQ-027 A changed level SHALL take effect on eff_k from the next tick on.

Reset
REQ-028 With RST_N = 0 at a CLK edge, the following SHALL all be zero at that edge, regardless of state and with no partial tick or move_en pulse emitted afterwards: state (IDLE), level, prescaler, lane counters, HIT counter, move_en.
REQ-029 move_dir SHALL equal LANE_DIR at all times, including during reset.

Verification (TICK_DIV=4, HIT_TICKS=3, defaults otherwise)
REQ-030 Reset, start held 1 -> state=1; move_en[0] pulses every 16 cycles, move_en[2] every 12, move_en[1] every 24; move_dir = 8'h55.
REQ-031 Three level_up pulses in RUN -> level=3; move_en[2] and move_en[7] pulse every 4 cycles (period clamped to 1); move_en[0] pulses every 4 cycles.
REQ-032 pause=1 for 40 cycles mid-period -> state=2, move_en=0 throughout; after release, lane0's next pulse completes the remaining ticks of its period.
REQ-033 collision and level_up in the same cycle in RUN -> state=3, level unchanged, move_en=0 for 3 ticks, then state=0.
REQ-034 Nine level_up pulses -> level saturates at 7; RST_N low for one cycle in RUN -> next cycle state=0, level=0, move_en=0.
